// File: rtl/imm_pkg.sv
// imm_pkg: shared pixel/channel types, default mask geometry and the
// stage-1 pipeline record for the image mask multiplier (imm_unit).
package imm_pkg;

    typedef logic [11:0] pixel_t;
    typedef logic [3:0]  channel_t;

    localparam int unsigned MASK_ROWS_DEFAULT = 64;
    localparam int unsigned MASK_COLS_DEFAULT = 64;
    localparam pixel_t      MASK_INIT_DEFAULT = 12'hFFF;

    // Input-to-output delay of imm_unit in clk cycles.
    localparam int unsigned IMM_LATENCY = 2;

    // Everything stage 2 needs about one pixel.
    typedef struct packed {
        pixel_t     pixel;
        pixel_t     mask;
        logic [8:0] row;
        logic [7:0] col;
        logic       in_win;
    } stage1_t;

endpackage

// File: rtl/imm_chan_mul.sv
// imm_chan_mul: one 4-bit colour channel scaled by a 4-bit mask value,
// result = ((image*mask)*17 + 128) >> 8, i.e. a rounded image*mask/15.
module imm_chan_mul
    import imm_pkg::*;
(
    input  channel_t image_c,
    input  channel_t mask_c,
    output channel_t result_c
);

    logic [7:0]  prod;
    logic [12:0] scaled;

    // 13-bit intermediate: 225*17+128 fits, so no overflow for any input pair.
    always_comb begin
        prod     = {4'b0, image_c} * {4'b0, mask_c};
        scaled   = {5'b0, prod} * 13'd17 + 13'd128;
        result_c = channel_t'(scaled >> 8);
    end

endmodule

// File: rtl/imm_unit.sv
// imm_unit: two-stage image mask multiplier. Stage 1 locates the pixel in
// the mask window and reads the mask entry; stage 2 scales each RGB444
// channel by the mask and blanks out-of-window pixels.
// Optional feature macro: IMM_MASK_WRITE_EN adds a writable mask memory;
// without it every mask entry is the constant MASK_INIT.
module imm_unit
    import imm_pkg::*;
#(
    parameter int unsigned MASK_ROWS = MASK_ROWS_DEFAULT,
    parameter int unsigned MASK_COLS = MASK_COLS_DEFAULT,
    parameter pixel_t      MASK_INIT = MASK_INIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] image_pixel,
    input  logic [8:0]  pixel_row,
    input  logic [7:0]  pixel_col,
    input  logic [8:0]  mask_row_offset,
    input  logic [7:0]  mask_col_offset,
    output logic [8:0]  pixel_row_out,
    output logic [7:0]  pixel_col_out,
    output logic [11:0] pixel_result
`ifdef IMM_MASK_WRITE_EN
    ,
    input  logic                         mask_we,
    input  logic [$clog2(MASK_ROWS)-1:0] mask_wrow,
    input  logic [$clog2(MASK_COLS)-1:0] mask_wcol,
    input  logic [11:0]                  mask_wdata
`endif
);

    logic [8:0] mr;
    logic [7:0] mc;
    logic       row_hit;
    logic       col_hit;
    pixel_t     mask_rd;
    stage1_t    s1;
    channel_t   res_r;
    channel_t   res_g;
    channel_t   res_b;

    // Window position; the >= guards stop a wrapped difference from
    // looking like a small in-range offset.
    always_comb begin
        mr      = pixel_row - mask_row_offset;
        mc      = pixel_col - mask_col_offset;
        row_hit = (pixel_row >= mask_row_offset) && (32'(mr) < MASK_ROWS);
        col_hit = (pixel_col >= mask_col_offset) && (32'(mc) < MASK_COLS);
    end

`ifdef IMM_MASK_WRITE_EN
    localparam int unsigned RW = $clog2(MASK_ROWS);
    localparam int unsigned CW = $clog2(MASK_COLS);

    pixel_t mask_mem [MASK_ROWS][MASK_COLS];

    // Mask memory write port; deliberately not reset.
    always_ff @(posedge clk) begin
        if (mask_we) begin
            mask_mem[mask_wrow][mask_wcol] <= mask_wdata;
        end
    end

    // Asynchronous read sampled into s1: a write on the same edge is not yet
    // visible, so that pixel gets the old entry.
    always_comb begin
        mask_rd = mask_mem[mr[RW-1:0]][mc[CW-1:0]];
    end
`else
    // Fixed mask: every entry reads as MASK_INIT.
    always_comb begin
        mask_rd = MASK_INIT;
    end
`endif

    // Stage 1 register: pixel, coordinates, window flag and mask entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
        end else begin
            s1 <= '{pixel:  image_pixel,
                    mask:   mask_rd,
                    row:    pixel_row,
                    col:    pixel_col,
                    in_win: row_hit && col_hit};
        end
    end

    imm_chan_mul u_mul_r (
        .image_c  (s1.pixel[11:8]),
        .mask_c   (s1.mask[11:8]),
        .result_c (res_r)
    );

    imm_chan_mul u_mul_g (
        .image_c  (s1.pixel[7:4]),
        .mask_c   (s1.mask[7:4]),
        .result_c (res_g)
    );

    imm_chan_mul u_mul_b (
        .image_c  (s1.pixel[3:0]),
        .mask_c   (s1.mask[3:0]),
        .result_c (res_b)
    );

    // Stage 2 register: scaled pixel (or black outside the window) plus
    // the coordinates that travel with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_result  <= '0;
            pixel_row_out <= '0;
            pixel_col_out <= '0;
        end else begin
            pixel_result  <= s1.in_win ? {res_r, res_g, res_b} : '0;
            pixel_row_out <= s1.row;
            pixel_col_out <= s1.col;
        end
    end

endmodule

// File: tb/tb_imm_unit.sv
// tb_imm_unit: scoreboard bench for imm_unit. Expected results are queued
// with the cycle they are due and compared on the falling edge.
// Mask-write scenarios are compiled in when IMM_MASK_WRITE_EN is defined.
module tb_imm_unit;
    import imm_pkg::*;

    localparam int unsigned ROWS = 64;
    localparam int unsigned COLS = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] image_pixel = '0;
    logic [8:0]  pixel_row = '0;
    logic [7:0]  pixel_col = '0;
    logic [8:0]  mask_row_offset = '0;
    logic [7:0]  mask_col_offset = '0;
    logic [8:0]  pixel_row_out;
    logic [7:0]  pixel_col_out;
    logic [11:0] pixel_result;
`ifdef IMM_MASK_WRITE_EN
    logic        mask_we = 1'b0;
    logic [5:0]  mask_wrow = '0;
    logic [6:0]  mask_wcol = '0;
    logic [11:0] mask_wdata = '0;
`endif

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int         due;
        logic [8:0] row;
        logic [7:0] col;
        pixel_t     res;
        string      name;
    } exp_t;

    typedef struct {
        string      name;
        logic [8:0] roff;
        logic [7:0] coff;
        logic [8:0] row;
        logic [7:0] col;
        pixel_t     pix;
        pixel_t     res;
    } vec_t;

    exp_t sb[$];

    imm_unit #(
        .MASK_ROWS (ROWS),
        .MASK_COLS (COLS),
        .MASK_INIT (12'hFFF)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .image_pixel     (image_pixel),
        .pixel_row       (pixel_row),
        .pixel_col       (pixel_col),
        .mask_row_offset (mask_row_offset),
        .mask_col_offset (mask_col_offset),
        .pixel_row_out   (pixel_row_out),
        .pixel_col_out   (pixel_col_out),
        .pixel_result    (pixel_result)
`ifdef IMM_MASK_WRITE_EN
        ,
        .mask_we         (mask_we),
        .mask_wrow       (mask_wrow),
        .mask_wcol       (mask_wcol),
        .mask_wdata      (mask_wdata)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        image_pixel = 12'hFFF;
        pixel_row = '0;
        pixel_col = '0;
        mask_row_offset = '0;
        mask_col_offset = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (pixel_result !== 12'h000) begin
            failures++;
            $display("FAIL reset_result: got %h expected 000", pixel_result);
        end
        checks++;
        if (pixel_row_out !== 9'd0) begin
            failures++;
            $display("FAIL reset_row: got %0d expected 0", pixel_row_out);
        end
        checks++;
        if (pixel_col_out !== 8'd0) begin
            failures++;
            $display("FAIL reset_col: got %0d expected 0", pixel_col_out);
        end
        rst_n = 1'b1;
        sb.push_back('{cyc + 2, 9'd0, 8'd0, 12'hFFF, "first_after_reset"});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (pixel_result !== e.res || pixel_row_out !== e.row || pixel_col_out !== e.col) begin
                    failures++;
                    $display("FAIL %s: got res=%h row=%0d col=%0d expected res=%h row=%0d col=%0d",
                             e.name, pixel_result, pixel_row_out, pixel_col_out, e.res, e.row, e.col);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL reset_drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_window();
        vec_t tv[$];
        exp_t e;
        tv.push_back('{"origin",         9'd0,   8'd0,   9'd0,   8'd0,   12'hFFF, 12'hFFF});
        tv.push_back('{"inner",          9'd0,   8'd0,   9'd21,  8'd88,  12'hCBD, 12'hCBD});
        tv.push_back('{"row_below_off",  9'd30,  8'd0,   9'd21,  8'd0,   12'hCBD, 12'h000});
        tv.push_back('{"row_94",         9'd0,   8'd0,   9'd94,  8'd0,   12'hCBD, 12'h000});
        tv.push_back('{"corner_in",      9'd0,   8'd0,   9'd63,  8'd127, 12'hA5F, 12'hA5F});
        tv.push_back('{"row_eq_rows",    9'd0,   8'd0,   9'd64,  8'd0,   12'hFFF, 12'h000});
        tv.push_back('{"col_eq_cols",    9'd0,   8'd0,   9'd0,   8'd128, 12'hFFF, 12'h000});
        tv.push_back('{"offset_in",      9'd100, 8'd200, 9'd163, 8'd255, 12'h123, 12'h123});
        tv.push_back('{"offset_row_out", 9'd100, 8'd200, 9'd164, 8'd255, 12'h123, 12'h000});
        tv.push_back('{"col_below_off",  9'd0,   8'd5,   9'd10,  8'd4,   12'hFFF, 12'h000});
        tv.push_back('{"max_coords_in",  9'd448, 8'd128, 9'd511, 8'd255, 12'h7E1, 12'h7E1});
        tv.push_back('{"row_no_wrap",    9'd500, 8'd0,   9'd20,  8'd0,   12'hFFF, 12'h000});
        tv.push_back('{"col_no_wrap",    9'd0,   8'd250, 9'd0,   8'd10,  12'hFFF, 12'h000});
        for (int i = 0; i < tv.size() + 4; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (pixel_result !== e.res || pixel_row_out !== e.row || pixel_col_out !== e.col) begin
                    failures++;
                    $display("FAIL %s: got res=%h row=%0d col=%0d expected res=%h row=%0d col=%0d",
                             e.name, pixel_result, pixel_row_out, pixel_col_out, e.res, e.row, e.col);
                end
            end
            if (i < tv.size()) begin
                mask_row_offset = tv[i].roff;
                mask_col_offset = tv[i].coff;
                pixel_row = tv[i].row;
                pixel_col = tv[i].col;
                image_pixel = tv[i].pix;
                sb.push_back('{cyc + 2, tv[i].row, tv[i].col, tv[i].res, tv[i].name});
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL window_drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back_reset();
        exp_t e;
        pixel_t pix [4] = '{12'h123, 12'h456, 12'h789, 12'hABC};
        mask_row_offset = '0;
        mask_col_offset = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (pixel_result !== e.res || pixel_row_out !== e.row || pixel_col_out !== e.col) begin
                    failures++;
                    $display("FAIL %s: got res=%h row=%0d col=%0d expected res=%h row=%0d col=%0d",
                             e.name, pixel_result, pixel_row_out, pixel_col_out, e.res, e.row, e.col);
                end
            end
            if (i < 4) begin
                pixel_row = 9'(i + 1);
                pixel_col = 8'd1;
                image_pixel = pix[i];
                sb.push_back('{cyc + 2, 9'(i + 1), 8'd1, pix[i], "stream"});
            end
        end
        // Third pixel is on the outputs and the fourth is in flight.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pixel_result !== 12'h000 || pixel_row_out !== 9'd0 || pixel_col_out !== 8'd0) begin
            failures++;
            $display("FAIL async_reset_clear: got res=%h row=%0d col=%0d expected 000/0/0",
                     pixel_result, pixel_row_out, pixel_col_out);
        end
        sb.delete();
        @(negedge clk);
        checks++;
        if (pixel_result !== 12'h000 || pixel_row_out !== 9'd0 || pixel_col_out !== 8'd0) begin
            failures++;
            $display("FAIL reset_held: got res=%h row=%0d col=%0d expected 000/0/0",
                     pixel_result, pixel_row_out, pixel_col_out);
        end
        rst_n = 1'b1;
        pixel_row = 9'd7;
        pixel_col = 8'd9;
        image_pixel = 12'hDEF;
        sb.push_back('{cyc + 2, 9'd7, 8'd9, 12'hDEF, "after_release"});
        @(negedge clk);
        checks++;
        if (pixel_result !== 12'h000 || pixel_row_out !== 9'd0 || pixel_col_out !== 8'd0) begin
            failures++;
            $display("FAIL flushed_pixel: got res=%h row=%0d col=%0d expected 000/0/0",
                     pixel_result, pixel_row_out, pixel_col_out);
        end
        for (int i = 0; i < 4; i++) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (pixel_result !== e.res || pixel_row_out !== e.row || pixel_col_out !== e.col) begin
                    failures++;
                    $display("FAIL %s: got res=%h row=%0d col=%0d expected res=%h row=%0d col=%0d",
                             e.name, pixel_result, pixel_row_out, pixel_col_out, e.res, e.row, e.col);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

`ifdef IMM_MASK_WRITE_EN
    typedef struct {
        string      name;
        logic       we;
        logic [5:0] wr;
        logic [6:0] wc;
        pixel_t     wd;
        logic [8:0] row;
        logic [7:0] col;
        pixel_t     pix;
        logic       chk;
        pixel_t     res;
    } wvec_t;

    task automatic test_mask_write();
        wvec_t tv[$];
        exp_t e;
        tv.push_back('{"seed_entry",     1'b1, 6'd0, 7'd0, 12'hFFF, 9'd0, 8'd0, 12'hFFF, 1'b0, 12'h000});
        tv.push_back('{"same_cycle_old", 1'b1, 6'd0, 7'd0, 12'h888, 9'd0, 8'd0, 12'hFFF, 1'b1, 12'hFFF});
        tv.push_back('{"written_888",    1'b1, 6'd1, 7'd2, 12'h5A3, 9'd0, 8'd0, 12'hFFF, 1'b1, 12'h888});
        tv.push_back('{"written_5a3",    1'b1, 6'd3, 7'd3, 12'h000, 9'd1, 8'd2, 12'hFFF, 1'b1, 12'h5A3});
        tv.push_back('{"half_by_half",   1'b0, 6'd0, 7'd0, 12'h000, 9'd0, 8'd0, 12'h888, 1'b1, 12'h444});
        tv.push_back('{"mask_zero",      1'b0, 6'd0, 7'd0, 12'h000, 9'd3, 8'd3, 12'hFFF, 1'b1, 12'h000});
        mask_row_offset = '0;
        mask_col_offset = '0;
        for (int i = 0; i < tv.size() + 4; i++) begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checks++;
                if (pixel_result !== e.res || pixel_row_out !== e.row || pixel_col_out !== e.col) begin
                    failures++;
                    $display("FAIL %s: got res=%h row=%0d col=%0d expected res=%h row=%0d col=%0d",
                             e.name, pixel_result, pixel_row_out, pixel_col_out, e.res, e.row, e.col);
                end
            end
            if (i < tv.size()) begin
                mask_we = tv[i].we;
                mask_wrow = tv[i].wr;
                mask_wcol = tv[i].wc;
                mask_wdata = tv[i].wd;
                pixel_row = tv[i].row;
                pixel_col = tv[i].col;
                image_pixel = tv[i].pix;
                if (tv[i].chk) begin
                    sb.push_back('{cyc + 2, tv[i].row, tv[i].col, tv[i].res, tv[i].name});
                end
            end else begin
                mask_we = 1'b0;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL mask_drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_window();
`ifdef IMM_MASK_WRITE_EN
        test_mask_write();
`endif
        test_back_to_back_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_unit.md
IMM_UNIT -- requirements
Module: imm_unit

Interface
REQ-001 Parameter MASK_ROWS, default 64, mask window height in pixels (power of two, at most 256).
REQ-002 Parameter MASK_COLS, default 64, mask window width in pixels (power of two, at most 256).
REQ-003 Parameter MASK_INIT, default 12'hFFF, value of every mask entry when the mask is not writable.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 image_pixel  in  12  RGB444 input pixel: R=[11:8], G=[7:4], B=[3:0].
REQ-008 pixel_row  in  9  image row of image_pixel.
REQ-009 pixel_col  in  8  image column of image_pixel.
REQ-010 mask_row_offset  in  9  image row where mask row 0 sits.
REQ-011 mask_col_offset  in  8  image column where mask column 0 sits.
REQ-012 pixel_row_out  out  9  pixel_row delayed to align with pixel_result.
REQ-013 pixel_col_out  out  8  pixel_col delayed to align with pixel_result.
REQ-014 pixel_result  out  12  masked RGB444 pixel.

Function
REQ-015 The block SHALL accept one pixel every cycle, with no handshake and no stall.
REQ-016 Latency from input to output SHALL be exactly 2 clk cycles for all outputs.
REQ-017 Stage 1 SHALL compute mr = pixel_row - mask_row_offset and mc = pixel_col - mask_col_offset, register them with the pixel, and read the mask entry M[mr][mc].
REQ-018 A pixel is in-window iff pixel_row >= mask_row_offset, mr < MASK_ROWS, pixel_col >= mask_col_offset and mc < MASK_COLS.
- Subtraction SHALL NOT wrap.
REQ-019 Stage 2, for each channel c: p = image_c * mask_c (8-bit), and result_c = (p*17 + 128) >> 8, truncated to 4 bits.
- Intermediates SHALL be at least 12 bits wide.
REQ-020 An in-window pixel SHALL output {R,G,B} results; an out-of-window pixel SHALL output 12'h000.
REQ-021 Boundary cases:
- Mask 0xF gives result_c = image_c; mask 0x0 gives 0.
- Offset 0 with row 0 is in-window; row MASK_ROWS is out-of-window.

Reset
REQ-022 While rst_n=0, all pipeline registers and outputs SHALL be 0, asynchronously.
REQ-023 Mask storage SHALL NOT be cleared by reset.
REQ-024 The first valid output SHALL appear 2 rising edges after rst_n deasserts.

Configuration
REQ-025 With macro IMM_MASK_WRITE_EN defined, the block SHALL add these ports and a MASK_ROWS x MASK_COLS x 12 mask memory:
- mask_we in 1
- mask_wrow in log2(MASK_ROWS)
- mask_wcol in log2(MASK_COLS)
- mask_wdata in 12
REQ-026 With IMM_MASK_WRITE_EN defined:
- A write on a clk edge with mask_we=1 SHALL be visible to stage-1 reads from the next cycle on.
- A same-cycle read SHALL return the old value.
REQ-027 Without IMM_MASK_WRITE_EN, the write ports and the memory SHALL be absent, and every in-window mask entry SHALL equal MASK_INIT.

Structure
REQ-028 Package imm_pkg SHALL hold:
- the pixel_t (12-bit) and channel_t (4-bit) typedefs;
- the default MASK_ROWS, MASK_COLS and MASK_INIT;
- the constant IMM_LATENCY = 2.
REQ-029 Sub-module imm_chan_mul SHALL implement the REQ-019 channel product and scale; it is instantiated 3 times.

Verification
REQ-030 Reset, then image 12'hFFF at row 0, col 0, offsets 0, default mask -> after 2 cycles result 12'hFFF, row_out 0, col_out 0.
REQ-031 Image 12'hCBD at row 21, col 88, offsets 0 -> after 2 cycles result 12'hCBD, row_out 21, col_out 88.
REQ-032 Row offset 30, pixel row 21 (and separately row 94 with MASK_ROWS 64), image 12'hCBD -> result 12'h000.
REQ-033 With IMM_MASK_WRITE_EN, write 12'h888 to entry [0][0], then image 12'hFFF at row 0, col 0 -> result 12'h888; same-cycle write-and-read -> old value.
REQ-034 Stream 4 back-to-back pixels, then assert rst_n=0 mid-stream -> outputs immediately 0; after release, the next pixel emerges 2 cycles later.
